// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and constants for the data-memory arbiter.
//   state_e  : sequencer states IDLE / ACCESS / MERGE / RESP
//   BE_FULL  : all four byte lanes enabled
//   BE_NONE  : no byte lane enabled
//   M0, M1   : grant ids for master 0 and master 1
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // True when only some of the lanes are enabled, which forces a read-modify-write.
  function automatic logic be_is_partial(input logic [3:0] be);
    return (be != BE_FULL) && (be != BE_NONE);
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge: combinational 4-lane byte merge.
//   i_old    : word currently held in memory
//   i_new    : lane-aligned store data
//   i_be     : byte enables; lane i taken from i_new when i_be[i] is set
//   o_merged : resulting full word
module dm_byte_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_be,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) begin
        o_merged[8*i +: 8] = i_new[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter and sequencer in front of a word-addressed data memory.
// Partial stores are turned into read-modify-write sequences, since the memory only
// accepts full-word writes.
//
// Ports:
//   clock, reset               : clock, asynchronous active-high reset
//   m0_* / m1_*                : req/we/addr/wdata/be in, ack/rdata out, per master
//   dm_addr, dm_wren, dm_wdata : memory address / write enable / write data
//   dm_rdata                   : memory combinational read data
//
// Build option: DM_ARB_FIXED_PRIO_EN -- when defined, master 0 always wins a tie and no
// round-robin pointer exists; otherwise the tie goes to the master named by the pointer.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_be,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_be,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] dm_addr,
  output logic          dm_wren,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);

  state_e        r_state;
  state_e        w_state_d;
  logic          r_we;
  logic [AW-3:0] r_word_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_be;
  logic          r_gnt;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_merged;

  logic          w_any_req;
  logic          w_pick;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [3:0]    w_sel_be;
  logic [DW-1:0] w_merged;
  logic          w_unused_addr;

  // Byte offsets never reach the memory.
  assign w_unused_addr = ^{m0_addr[1:0], m1_addr[1:0]};

  assign w_any_req = m0_req | m1_req;

`ifdef DM_ARB_FIXED_PRIO_EN
  assign w_pick = m0_req ? M0 : M1;
`else
  logic r_ptr;

  always_comb begin
    if (m0_req && m1_req) begin
      w_pick = r_ptr;
    end else begin
      w_pick = m0_req ? M0 : M1;
    end
  end

  // After each response the tie-break favours the master that was not served.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= M0;
    end else if (r_state == RESP) begin
      r_ptr <= ~r_gnt;
    end
  end
`endif

  assign w_sel_we    = (w_pick == M1) ? m1_we    : m0_we;
  assign w_sel_addr  = (w_pick == M1) ? m1_addr  : m0_addr;
  assign w_sel_wdata = (w_pick == M1) ? m1_wdata : m0_wdata;
  assign w_sel_be    = (w_pick == M1) ? m1_be    : m0_be;

  dm_byte_merge u_merge (
    .i_old    (dm_rdata),
    .i_new    (r_wdata),
    .i_be     (r_be),
    .o_merged (w_merged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_word_addr <= '0;
      r_wdata     <= '0;
      r_be        <= BE_NONE;
      r_gnt       <= M0;
      r_rdata     <= '0;
      r_merged    <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == IDLE && w_any_req) begin
        r_we        <= w_sel_we;
        r_word_addr <= w_sel_addr[AW-1:2];
        r_wdata     <= w_sel_wdata;
        r_be        <= w_sel_be;
        r_gnt       <= w_pick;
      end
      // The word seen in ACCESS is the pre-write value; it is both returned and merged.
      if (r_state == ACCESS) begin
        r_rdata  <= dm_rdata;
        r_merged <= w_merged;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_state_d = ACCESS;
      ACCESS:  w_state_d = (r_we && be_is_partial(r_be)) ? MERGE : RESP;
      MERGE:   w_state_d = RESP;
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Memory controls decode straight from state so reset removes a write at once.
  always_comb begin
    dm_wren  = 1'b0;
    dm_wdata = r_wdata;
    unique case (r_state)
      ACCESS: dm_wren = r_we && (r_be == BE_FULL);
      MERGE: begin
        dm_wren  = 1'b1;
        dm_wdata = r_merged;
      end
      default: ;
    endcase
  end

  assign dm_addr = {r_word_addr, 2'b00};

  assign m0_ack   = (r_state == RESP) && (r_gnt == M0);
  assign m1_ack   = (r_state == RESP) && (r_gnt == M1);
  assign m0_rdata = r_rdata;
  assign m1_rdata = r_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter with a behavioural memory and a
// byte-level reference memory; directed scenarios plus randomized transactions.
module tb_dm_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_wren;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model with a backdoor port for presetting words.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;
  int          wren_cnt = 0;

  always #5 clock = ~clock;

  assign dm_rdata = mem[dm_addr[11:2]];

  always @(posedge clock) begin
    if (bd_we) mem[bd_idx] <= bd_val;
    if (dm_wren) begin
      mem[dm_addr[11:2]] <= dm_wdata;
      wren_cnt = wren_cnt + 1;
    end
  end

  dm_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_be    (m0_be),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_be    (m1_be),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .dm_addr  (dm_addr),
    .dm_wren  (dm_wren),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata)
  );

  function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic logic ack_of(input int m);
    return (m == 1) ? m1_ack : m0_ack;
  endfunction

  function automatic logic [31:0] rdata_of(input int m);
    return (m == 1) ? m1_rdata : m0_rdata;
  endfunction

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (m == 1) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end
  endtask

  task automatic preset(input logic [31:0] addr, input logic [31:0] val);
    bd_idx = addr[11:2];
    bd_val = val;
    bd_we  = 1'b1;
    ref_mem[addr[11:2]] = val;
    @(posedge clock); #1;
    bd_we = 1'b0;
  endtask

  // One complete transaction from master m; checks address, write timing, latency,
  // returned pre-write word and the resulting memory contents.
  task automatic do_txn(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input string nm);
    logic [31:0] exp_rd;
    logic        exp_acc_wren;
    int          exp_lat, exp_wr, w0, n;
    bit          got;
    exp_rd       = ref_mem[addr[11:2]];
    exp_lat      = (we && be != 4'hF && be != 4'h0) ? 3 : 2;
    exp_wr       = (we && be != 4'h0) ? 1 : 0;
    exp_acc_wren = we && (be == 4'hF);
    w0  = wren_cnt;
    drive(m, 1'b1, we, addr, wdata, be);
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) begin
        n_tests++;
        if (dm_addr !== {addr[31:2], 2'b00}) begin
          n_fail++;
          $display("FAIL %s addr: got %h want %h", nm, dm_addr, {addr[31:2], 2'b00});
        end
        n_tests++;
        if (dm_wren !== exp_acc_wren) begin
          n_fail++;
          $display("FAIL %s access_wren: got %b want %b", nm, dm_wren, exp_acc_wren);
        end
      end
      if (ack_of(m) === 1'b1) got = 1;
    end
    drive(m, 1'b0, we, addr, wdata, be);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no ack after %0d cycles, want %0d", nm, n, exp_lat);
    end else begin
      if (n != exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", nm, n, exp_lat);
      end
      n_tests++;
      if (rdata_of(m) !== exp_rd) begin
        n_fail++;
        $display("FAIL %s rdata: got %h want %h", nm, rdata_of(m), exp_rd);
      end
      n_tests++;
      if (ack_of(1 - m) !== 1'b0) begin
        n_fail++;
        $display("FAIL %s other_ack: got %b want 0", nm, ack_of(1 - m));
      end
      n_tests++;
      if (wren_cnt - w0 != exp_wr) begin
        n_fail++;
        $display("FAIL %s wren_count: got %0d want %0d", nm, wren_cnt - w0, exp_wr);
      end
    end
    if (we) ref_mem[addr[11:2]] = apply_be(ref_mem[addr[11:2]], wdata, be);
    @(posedge clock); #1;
    n_tests++;
    if (mem[addr[11:2]] !== ref_mem[addr[11:2]]) begin
      n_fail++;
      $display("FAIL %s mem: got %h want %h", nm, mem[addr[11:2]], ref_mem[addr[11:2]]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    n_tests++;
    if ({m0_ack, m1_ack, dm_wren} !== 3'b000 || dm_addr !== 32'h0 || dm_wdata !== 32'h0 ||
        m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: acks %b%b wren %b addr %h wdata %h rdata %h/%h want zeros",
               m0_ack, m1_ack, dm_wren, dm_addr, dm_wdata, m0_rdata, m1_rdata);
    end
    for (int i = 0; i < 32; i++) preset(i * 4, $urandom);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if ({m0_ack, m1_ack, dm_wren} !== 3'b000 || dm_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_no_req: acks %b%b wren %b addr %h want zeros",
               m0_ack, m1_ack, dm_wren, dm_addr);
    end
  endtask

  task automatic test_full_write_read();
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "m0_full_write");
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'hF, "m0_read");
    n_tests++;
    if (ref_mem[4] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL full_write_value: got %h want deadbeef", ref_mem[4]);
    end
  endtask

  task automatic test_partial_write();
    preset(32'h20, 32'h11223344);
    do_txn(1, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, "m1_partial_write");
    do_txn(1, 1'b0, 32'h20, 32'h0, 4'hF, "m1_read_merged");
    n_tests++;
    if (mem[8] !== 32'h1122AA44) begin
      n_fail++;
      $display("FAIL partial_value: got %h want 1122aa44", mem[8]);
    end
  endtask

  task automatic test_be_none();
    preset(32'h30, 32'h55);
    do_txn(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, "be_none_write");
    n_tests++;
    if (mem[12] !== 32'h55) begin
      n_fail++;
      $display("FAIL be_none_value: got %h want 00000055", mem[12]);
    end
  endtask

  task automatic test_arbitration();
    int  order[$];
    int  exp_order[4];
    int  cnt0, cnt1;
    bit  raise0, raise1;
`ifdef DM_ARB_FIXED_PRIO_EN
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 1;
`else
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`endif
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    cnt0 = 0; cnt1 = 0; raise0 = 0; raise1 = 0;
    drive(0, 1'b1, 1'b0, 32'h00, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(posedge clock); #1;
      if (raise0) begin m0_req = 1'b1; raise0 = 0; end
      if (raise1) begin m1_req = 1'b1; raise1 = 0; end
      if (m0_ack === 1'b1) begin
        order.push_back(0); cnt0++; m0_req = 1'b0;
        if (cnt0 < 2) raise0 = 1;
      end
      if (m1_ack === 1'b1) begin
        order.push_back(1); cnt1++; m1_req = 1'b0;
        if (cnt1 < 2) raise1 = 1;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    n_tests++;
    if (order.size() != 4) begin
      n_fail++;
      $display("FAIL arb_count: got %0d grants want 4", order.size());
    end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      n_tests++;
      if (order[i] != exp_order[i]) begin
        n_fail++;
        $display("FAIL arb_order[%0d]: got m%0d want m%0d", i, order[i], exp_order[i]);
      end
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_in_merge();
    preset(32'h40, 32'hA5A5A5A5);
    drive(1, 1'b1, 1'b1, 32'h40, 32'h000000FF, 4'b0001);
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (dm_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL merge_wren: got %b want 1", dm_wren);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({dm_wren, m0_ack, m1_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_merge_outputs: wren %b acks %b%b want 000", dm_wren, m0_ack, m1_ack);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (mem[16] !== 32'hA5A5A5A5 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_merge_word: got %h acks %b%b want a5a5a5a5 acks 00",
               mem[16], m0_ack, m1_ack);
    end
    do_txn(1, 1'b0, 32'h40, 32'h0, 4'hF, "post_reset_read");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int          n, w0;
    bit          got;
    d  = $urandom;
    w0 = wren_cnt;
    drive(0, 1'b1, 1'b1, 32'h50, d, 4'hF);
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clock); #1; n++;
      if (m0_ack === 1'b1) got = 1;
    end
    ref_mem[20] = d;
    // Keep req high across the following IDLE sample, then release.
    @(posedge clock); #1;
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b1, 32'h50, d, 4'hF);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL b2b_first_ack: timeout after %0d cycles", n);
    end
    n = 0; got = 0;
    while (!got && n < 20) begin
      if (m0_ack === 1'b1) got = 1;
      else begin @(posedge clock); #1; n++; end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL b2b_second_ack: none within %0d cycles", n);
    end else begin
      n_tests++;
      if (m0_rdata !== ref_mem[20]) begin
        n_fail++;
        $display("FAIL b2b_rdata: got %h want %h", m0_rdata, ref_mem[20]);
      end
    end
    n_tests++;
    if (wren_cnt - w0 != 2) begin
      n_fail++;
      $display("FAIL b2b_wren_count: got %0d want 2", wren_cnt - w0);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        we;
    int          m;
    for (int i = 0; i < 40; i++) begin
      m     = int'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = $urandom;
      addr[11:6] = 6'd0;
      wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       be = 4'h0;
        1:       be = 4'hF;
        default: be = 4'($urandom_range(1, 14));
      endcase
      do_txn(m, we, addr, wdata, be, "random");
    end
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_be_none();
    test_arbitration();
    test_reset_in_merge();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
